bch_encoder_p: RTL and testbench
================================

Name: bch_encoder_p

Overview:
- Parametrised systematic BCH/cyclic-code encoder. Successor to the fixed (63,56) serial encoder. Default polynomial g(x)=x^7+x^6+x^2+1.
- Builds a K-bit message: a constant pad (PAD_VAL, K-MSG_W bits) followed by a MSG_W-bit payload.
- Shifts the message MSB-first through a P-bit LFSR and presents the N-bit codeword {message, parity}.
- Adds valid/ready handshakes on input and output, output hold under backpressure, a synchronous flush, and back-to-back codeword operation.
- Sits between the payload source and the channel/serialiser.

Parameters:
N, 63, codeword length in bits
K, 56, message length in bits; P = N-K parity bits (derived localparam)
MSG_W, 32, payload width; 1 <= MSG_W <= K
PAD_VAL, 24'h555555, constant upper message bits, width K-MSG_W (ignored when MSG_W==K)
GEN_POLY, 8'hC5, generator polynomial, P+1 bits, bit i = coeff of x^i; bits P and 0 must be 1
CNT_W, $clog2(K+1), shift-counter width (derived)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset (sampled on rising edge of clk)
flush  input  1  synchronous abort; returns block to IDLE
msg  input  MSG_W  payload
msg_valid  input  1  payload available
msg_ready  output  1  block can accept payload
cw  output  N  codeword {PAD_VAL, payload, parity[P-1:0]}
cw_valid  output  1  codeword valid
cw_ready  input  1  downstream accepts codeword
busy  output  1  high in SHIFT or OUT

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, parity reg=0, shift reg=0, counter=0, cw=0, cw_valid=0, msg_ready=1, busy=0. Reset has priority over flush and all handshakes, and aborts any operation in progress.
- States: IDLE, SHIFT, OUT.
- msg_ready = (state==IDLE), combinational from state. cw_valid = (state==OUT).
- IDLE:
  - On an edge with msg_valid && msg_ready: shift reg <= {PAD_VAL, msg}, hold reg <= same, parity <= 0, counter <= K, state -> SHIFT.
- SHIFT (one message bit per clock, MSB first):
  - fb = parity[P-1] ^ shift[K-1].
  - parity <= {parity[P-2:0],1'b0} ^ (fb ? GEN_POLY[P-1:0] : 0).
  - shift <= shift<<1; counter <= counter-1.
  - When counter==1 at the edge, state -> OUT. This gives exactly K shift edges.
- Latency: cw_valid rises exactly K clock edges after the acceptance edge. Minimum turnaround is K+2 cycles per codeword (accept, K shifts, output accept).
- OUT:
  - cw = {hold reg, parity}.
  - cw and cw_valid stay stable while cw_ready=0, for any number of cycles.
  - On an edge with cw_ready=1: state -> IDLE, cw_valid falls next cycle, msg_ready rises next cycle. There is no same-cycle accept of a new message.
- cw output is 0 in IDLE and SHIFT. No partial parity is exposed.
- flush=1 at an edge (rst_n high): state -> IDLE, parity=0, cw_valid=0. Any held codeword is discarded. A msg_valid in the same cycle is NOT accepted; flush has priority.
- msg changes while not accepted: ignored. Payload is sampled only on the acceptance edge.
- cw_ready in IDLE/SHIFT: ignored.
- Parity equals the remainder of m(x)*x^P mod g(x). The encoder is linear: parity(a^b) = parity(a)^parity(b).
- Elaboration checks (synthesis-time error):
  - N>K
  - MSG_W<=K
  - GEN_POLY[P]==1 and GEN_POLY[0]==1

Test Plan:
- PAD_VAL=0, msg=0 -> cw_valid high exactly 56 edges after accept; cw=0, parity=7'h00.
- PAD_VAL=0, msg=32'h1 -> parity=7'h45. msg=32'h2 -> parity=7'h4F. msg=32'h3 -> parity=7'h0A (linearity).
- Defaults, msg=32'hDEADBEEF, 100 random payloads -> cw[62:7]=={24'h555555,msg}. Parity matches a golden polynomial-division model. Every cw is a multiple of g(x) (remainder 0).
- cw_ready held 0 for 20 cycles after cw_valid -> cw and cw_valid stable; msg_ready=0 throughout; msg_valid pulses ignored. cw_ready=1 -> IDLE, next message accepted the following cycle.
- flush at shift count 30 -> next cycle IDLE, msg_ready=1, cw_valid never asserted. A fresh msg=32'h1 (PAD 0) then yields parity 7'h45 (no stale state).
- rst_n low for 1 cycle mid-SHIFT and during OUT -> all outputs at reset values the next cycle. Back-to-back messages with cw_ready tied 1 -> one codeword every 58 cycles.

Source files
------------

// File: rtl/bch_encoder_p_if.sv
// Handshake bundle between a payload source/codeword sink and the BCH encoder.
// The encoder attaches through the slave modport; the environment uses master.
interface bch_encoder_p_if #(
   parameter int N     = 63,
   parameter int MSG_W = 32
);
   logic             flush;
   logic [MSG_W-1:0] msg;
   logic             msg_valid;
   logic             msg_ready;
   logic [N-1:0]     cw;
   logic             cw_valid;
   logic             cw_ready;
   logic             busy;

   modport master (
      output flush, msg, msg_valid, cw_ready,
      input  msg_ready, cw, cw_valid, busy
   );

   modport slave (
      input  flush, msg, msg_valid, cw_ready,
      output msg_ready, cw, cw_valid, busy
   );
endinterface

// File: rtl/bch_encoder_p.sv
// Parametrised systematic cyclic/BCH encoder: pads the payload to K bits, shifts it
// MSB-first through a P-bit division LFSR and presents {message, parity} with valid/ready.
module bch_encoder_p #(
   parameter int N     = 63,
   parameter int K     = 56,
   parameter int MSG_W = 32,
   parameter logic [((K > MSG_W) ? (K - MSG_W) : 1) - 1:0] PAD_VAL = 24'h555555,
   parameter logic [N-K:0] GEN_POLY = 8'hC5
) (
   input logic             clk,
   input logic             rst_n,
   bch_encoder_p_if.slave  io
);
   localparam int P     = N - K;
   localparam int CNT_W = $clog2(K + 1);
   // When MSG_W == K the shift pushes the pad completely out, leaving no pad bits.
   localparam logic [K-1:0] PAD_EXT = K'(PAD_VAL) << MSG_W;

   generate
      if (N <= K) begin : g_bad_nk
         $error("bch_encoder_p: N must be greater than K");
      end
      if ((MSG_W < 1) || (MSG_W > K)) begin : g_bad_msg_w
         $error("bch_encoder_p: MSG_W must be in 1..K");
      end
      if ((GEN_POLY[P] != 1'b1) || (GEN_POLY[0] != 1'b1)) begin : g_bad_poly
         $error("bch_encoder_p: GEN_POLY needs x^P and x^0 terms");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t           state_r;
   logic [P-1:0]     parity_r;
   logic [K-1:0]     shift_r;
   logic [K-1:0]     hold_r;
   logic [CNT_W-1:0] cnt_r;
   logic [N-1:0]     cw_r;
   logic [P-1:0]     parity_next_s;

   function automatic logic [P-1:0] parity_step(input logic [P-1:0] par, input logic din);
      logic fb;
      fb = par[P-1] ^ din;
      parity_step = (par << 1) ^ (fb ? GEN_POLY[P-1:0] : {P{1'b0}});
   endfunction

   // Next LFSR remainder for the message bit currently at the top of the shift register
   always_comb begin
      parity_next_s = parity_step(parity_r, shift_r[K-1]);
   end

   // Handshake FSM, message/parity datapath and registered codeword
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         parity_r <= '0;
         shift_r  <= '0;
         hold_r   <= '0;
         cnt_r    <= '0;
         cw_r     <= '0;
      end else if (io.flush) begin
         state_r  <= IDLE;
         parity_r <= '0;
         cnt_r    <= '0;
         cw_r     <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (io.msg_valid) begin
                  shift_r  <= PAD_EXT | K'(io.msg);
                  hold_r   <= PAD_EXT | K'(io.msg);
                  parity_r <= '0;
                  cnt_r    <= CNT_W'(K);
                  state_r  <= SHIFT;
               end
            end
            SHIFT: begin
               parity_r <= parity_next_s;
               shift_r  <= shift_r << 1;
               cnt_r    <= cnt_r - CNT_W'(1);
               // Last message bit: the codeword register is loaded with the final remainder
               if (cnt_r == CNT_W'(1)) begin
                  cw_r    <= {hold_r, parity_next_s};
                  state_r <= OUT;
               end
            end
            OUT: begin
               if (io.cw_ready) begin
                  cw_r    <= '0;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               cw_r    <= '0;
            end
         endcase
      end
   end

   assign io.msg_ready = (state_r == IDLE);
   assign io.cw_valid  = (state_r == OUT);
   assign io.busy      = (state_r == SHIFT) || (state_r == OUT);
   assign io.cw        = cw_r;

endmodule

// File: tb/tb_bch_encoder_p.sv
// Scoreboard bench for bch_encoder_p: a default-pad instance and a zero-pad instance,
// expected codewords from a long-division model, checked as codewords leave the DUT.
module tb_bch_encoder_p;
   localparam int N = 63;
   localparam int K = 56;
   localparam int P = 7;
   localparam logic [7:0] GP = 8'hC5;

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic [31:0] msg;
   logic        msg_valid;
   logic        cw_ready;
   logic        flush;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [N-1:0] sb_q[$];

   bch_encoder_p_if #(.N(N), .MSG_W(32)) if_d ();
   bch_encoder_p_if #(.N(N), .MSG_W(32)) if_z ();

   bch_encoder_p dut_d (.clk(clk), .rst_n(rst_n), .io(if_d));
   bch_encoder_p #(.PAD_VAL(24'h000000)) dut_z (.clk(clk), .rst_n(rst_n), .io(if_z));

   assign if_d.msg       = msg;
   assign if_z.msg       = msg;
   assign if_d.msg_valid = msg_valid & ~sel;
   assign if_z.msg_valid = msg_valid & sel;
   assign if_d.cw_ready  = cw_ready;
   assign if_z.cw_ready  = cw_ready;
   assign if_d.flush     = flush;
   assign if_z.flush     = flush;

   logic         obs_ready, obs_valid, obs_busy;
   logic [N-1:0] obs_cw;
   assign obs_ready = sel ? if_z.msg_ready : if_d.msg_ready;
   assign obs_valid = sel ? if_z.cw_valid  : if_d.cw_valid;
   assign obs_busy  = sel ? if_z.busy      : if_d.busy;
   assign obs_cw    = sel ? if_z.cw        : if_d.cw;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", tag, obs, exp);
      end
   endtask

   // Remainder of v(x) divided by g(x), by plain long division
   function automatic logic [P-1:0] poly_rem(input logic [N-1:0] v);
      logic [N-1:0] r;
      r = v;
      for (int i = N - 1; i >= P; i--)
         if (r[i]) r = r ^ (N'(GP) << (i - P));
      return r[P-1:0];
   endfunction

   function automatic logic [N-1:0] exp_cw(input logic pad_on, input logic [31:0] m);
      logic [K-1:0] mm;
      mm = {(pad_on ? 24'h555555 : 24'h000000), m};
      return {mm, poly_rem({mm, 7'b0000000})};
   endfunction

   // Called at a negedge; returns at the negedge after the acceptance edge
   task automatic send(input logic [31:0] m, input bit push, output int acc_cyc, output int w);
      w = 0;
      msg = m;
      msg_valid = 1'b1;
      while (!obs_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check_value("accept_timeout", {63'd0, obs_ready}, 64'd1);
      @(posedge clk);
      if (push) sb_q.push_back(exp_cw(~sel, m));
      @(negedge clk);
      acc_cyc = cyc;
      msg_valid = 1'b0;
   endtask

   task automatic receive(input int acc_cyc, input bit chk_lat, output logic [N-1:0] got);
      int w;
      w = 0;
      while (!obs_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      check_value("cw_timeout", {63'd0, obs_valid}, 64'd1);
      if (chk_lat) check_value("latency", 64'(cyc - acc_cyc), 64'(K));
      got = obs_cw;
      check_value("cw_mod_g", 64'(poly_rem(obs_cw)), 64'd0);
      if (sb_q.size() > 0) check_value("cw", 64'(obs_cw), 64'(sb_q.pop_front()));
      else check_value("sb_empty", 64'(sb_q.size()), 64'd1);
      cw_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cw_ready = 1'b0;
      check_value("ready_after_out", {63'd0, obs_ready}, 64'd1);
      check_value("valid_after_out", {63'd0, obs_valid}, 64'd0);
   endtask

   task automatic check_reset();
      check_value("rst_ready", {63'd0, obs_ready}, 64'd1);
      check_value("rst_valid", {63'd0, obs_valid}, 64'd0);
      check_value("rst_busy",  {63'd0, obs_busy},  64'd0);
      check_value("rst_cw",    64'(obs_cw),        64'd0);
   endtask

   initial begin
      int acc, w, nacc, nrx, last;
      bit pend, seen;
      logic [N-1:0] got, ref_cw;
      logic [P-1:0] p1, p2, p3;

      rst_n = 1'b0; sel = 1'b0; msg = 32'd0; msg_valid = 1'b0; cw_ready = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check_reset();
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Zero pad: known remainders and linearity
      sel = 1'b1;
      send(32'h0, 1'b1, acc, w);
      receive(acc, 1'b1, got);
      check_value("zero_cw", 64'(got), 64'd0);
      send(32'h1, 1'b1, acc, w);
      receive(acc, 1'b1, got);
      p1 = got[P-1:0];
      check_value("par_m1", 64'(p1), 64'h45);
      send(32'h2, 1'b1, acc, w);
      receive(acc, 1'b1, got);
      p2 = got[P-1:0];
      check_value("par_m2", 64'(p2), 64'h4F);
      send(32'h3, 1'b1, acc, w);
      receive(acc, 1'b1, got);
      p3 = got[P-1:0];
      check_value("par_m3", 64'(p3), 64'h0A);
      check_value("linear", 64'(p3), 64'(p1 ^ p2));

      // Default pad: fixed and random payloads
      sel = 1'b0;
      send(32'hDEADBEEF, 1'b1, acc, w);
      receive(acc, 1'b1, got);
      check_value("msg_field", 64'(got[N-1:P]), {8'h00, 24'h555555, 32'hDEADBEEF});
      for (int i = 0; i < 100; i++) begin
         send($urandom, 1'b1, acc, w);
         receive(acc, 1'b1, got);
      end

      // Backpressure: output held, msg_valid pulses ignored
      send(32'h12345678, 1'b1, acc, w);
      w = 0;
      while (!obs_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      ref_cw = obs_cw;
      for (int i = 0; i < 20; i++) begin
         check_value("bp_cw", 64'(obs_cw), 64'(ref_cw));
         check_value("bp_valid", {63'd0, obs_valid}, 64'd1);
         check_value("bp_ready", {63'd0, obs_ready}, 64'd0);
         msg = $urandom;
         msg_valid = i[0];
         @(negedge clk);
      end
      msg_valid = 1'b0;
      receive(acc, 1'b0, got);
      send(32'hCAFEF00D, 1'b1, acc, w);
      check_value("bp_next_accept", 64'(w), 64'd0);
      receive(acc, 1'b1, got);

      // Flush mid-shift, then flush beating msg_valid in IDLE
      sel = 1'b1;
      send(32'hDEADBEEF, 1'b0, acc, w);
      repeat (30) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_value("fl_ready", {63'd0, obs_ready}, 64'd1);
      check_value("fl_valid", {63'd0, obs_valid}, 64'd0);
      check_value("fl_busy",  {63'd0, obs_busy},  64'd0);
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (obs_valid) seen = 1'b1;
         @(negedge clk);
      end
      check_value("fl_no_valid", {63'd0, seen}, 64'd0);
      flush = 1'b1;
      msg = 32'h5;
      msg_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      msg_valid = 1'b0;
      check_value("fl_priority", {63'd0, obs_busy}, 64'd0);
      send(32'h1, 1'b1, acc, w);
      receive(acc, 1'b1, got);
      check_value("fl_par_m1", 64'(got[P-1:0]), 64'h45);

      // Reset mid-shift and during output
      sel = 1'b0;
      send(32'hA5A5A5A5, 1'b0, acc, w);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset();
      send(32'h5A5A5A5A, 1'b0, acc, w);
      w = 0;
      while (!obs_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      check_value("out_reached", {63'd0, obs_valid}, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset();

      // Back-to-back with cw_ready tied high
      cw_ready = 1'b1;
      msg = $urandom;
      msg_valid = 1'b1;
      nacc = 0; nrx = 0; last = -1; pend = 1'b0;
      for (int c = 0; c < 400 && nrx < 4; c++) begin
         if (obs_valid) begin
            if (sb_q.size() > 0) check_value("b2b_cw", 64'(obs_cw), 64'(sb_q.pop_front()));
            else check_value("b2b_sb_empty", 64'(sb_q.size()), 64'd1);
            if (last >= 0) check_value("b2b_period", 64'(cyc - last), 64'(K + 2));
            last = cyc;
            nrx++;
         end
         if (obs_ready) begin
            if (nacc < 4) begin
               sb_q.push_back(exp_cw(1'b1, msg));
               nacc++;
               pend = 1'b1;
            end else begin
               msg_valid = 1'b0;
            end
         end
         @(negedge clk);
         if (pend) begin
            msg = $urandom;
            pend = 1'b0;
         end
      end
      cw_ready = 1'b0;
      msg_valid = 1'b0;
      check_value("b2b_count", 64'(nrx), 64'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
